// File: rtl/iq_path_switch.sv
// I/Q source-to-channel router with per-channel transform and glitch-free re-routing.
// Each channel is a two-stage pipeline (mux, transform) with a guard FSM in front of it.

module iq_path_ch #(
  parameter int DW        = 16,
  parameter int NUM_SRC   = 4,
  parameter int SEL_W     = 4,
  parameter int GUARD_LEN = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0][DW-1:0]    src_i,
  input  logic [NUM_SRC-1:0][DW-1:0]    src_q,
  input  logic [NUM_SRC-1:0]            src_v,
  input  logic                          cfg_valid,
  input  logic [SEL_W-1:0]              cfg_sel,
  input  logic [1:0]                    cfg_mode,
  output logic [DW-1:0]                 out_i,
  output logic [DW-1:0]                 out_q,
  output logic                          out_v,
  output logic                          busy,
  output logic                          done,
  output logic                          bad
);
  localparam int STAGES = 2;
  localparam logic [1:0] M_PASS = 2'd0, M_CONJ = 2'd1, M_SWAP = 2'd2, M_MUTE = 2'd3;
  localparam logic [SEL_W:0] NSRC = (SEL_W+1)'(NUM_SRC);
  localparam logic [15:0] GLOAD = 16'(GUARD_LEN - 1);
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic {RUN, GUARD} state_t;
  typedef struct packed {
    logic [DW-1:0] i;
    logic [DW-1:0] q;
  } iq_t;

  state_t           state;
  logic [15:0]      gcnt;
  logic [SEL_W-1:0] act_sel, pend_sel, rd_sel;
  logic [1:0]       act_mode, pend_mode;
  iq_t              mux_iq, s1, s2_n, s2;
  logic             mux_v;
  logic [STAGES:0]  vld_pipe;

  function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] x);
    return (x == MIN_NEG) ? MAX_POS : (~x + 1'b1);
  endfunction

  assign bad  = cfg_valid && ({1'b0, cfg_sel} >= NSRC);
  assign done = (state == GUARD) && (gcnt == '0) && !cfg_valid;
  assign busy = (state == GUARD);

  // During the guard the pending source already drives the strobe so the rate never breaks.
  assign rd_sel = (state == GUARD) ? pend_sel : act_sel;

  always_comb begin
    mux_iq = '0;
    mux_v  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (rd_sel == SEL_W'(k)) begin
        mux_iq = '{i: src_i[k], q: src_q[k]};
        mux_v  = src_v[k];
      end
    end
    if (state == GUARD) mux_iq = '0;
  end

  assign vld_pipe[0] = mux_v;

  always_comb begin
    s2_n = '0;
    case (act_mode)
      M_PASS:  s2_n = s1;
      M_CONJ:  s2_n = '{i: s1.i, q: neg_sat(s1.q)};
      M_SWAP:  s2_n = '{i: s1.q, q: s1.i};
      default: s2_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1                   <= '0;
      s2                   <= '0;
      vld_pipe[STAGES:1]   <= '0;
      state                <= RUN;
      gcnt                 <= '0;
      act_sel              <= '0;
      act_mode             <= M_MUTE;
      pend_sel             <= '0;
      pend_mode            <= M_MUTE;
    end else begin
      s1                 <= mux_iq;
      s2                 <= s2_n;
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (cfg_valid) begin
        if (bad) begin
          act_mode <= M_MUTE;
          state    <= RUN;
          gcnt     <= '0;
        end else if (state == GUARD || cfg_sel != act_sel) begin
          pend_sel  <= cfg_sel;
          pend_mode <= cfg_mode;
          state     <= GUARD;
          gcnt      <= GLOAD;
        end else begin
          act_mode <= cfg_mode;
        end
      end else if (state == GUARD) begin
        if (gcnt == '0) begin
          state    <= RUN;
          act_sel  <= pend_sel;
          act_mode <= pend_mode;
        end else begin
          gcnt <= gcnt - 1'b1;
        end
      end
    end
  end

  assign out_i = s2.i;
  assign out_q = s2.q;
  assign out_v = vld_pipe[STAGES];
endmodule

module iq_path_switch #(
  parameter int DW        = 16,
  parameter int NUM_SRC   = 4,
  parameter int NUM_CH    = 2,
  parameter int SEL_W     = 4,
  parameter int GUARD_LEN = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DW-1:0]     src_i_tdata,
  input  logic [NUM_SRC*DW-1:0]     src_q_tdata,
  input  logic [NUM_SRC-1:0]        src_tvalid,
  input  logic [NUM_CH*SEL_W-1:0]   sel_in,
  input  logic [NUM_CH*2-1:0]       mode_in,
  input  logic                      cfg_valid,
  output logic [NUM_CH*DW-1:0]      out_i_tdata,
  output logic [NUM_CH*DW-1:0]      out_q_tdata,
  output logic [NUM_CH-1:0]         out_tvalid,
  output logic [NUM_CH-1:0]         ch_busy,
  output logic                      sel_err,
  output logic [15:0]               switch_cnt
);
  logic [NUM_SRC-1:0][DW-1:0] src_i, src_q;
  logic [NUM_CH-1:0][DW-1:0]  ch_i, ch_q;
  logic [NUM_CH-1:0]          done, bad;
  logic [4:0]                 n_done;
  logic [16:0]                cnt_sum;

  assign src_i       = src_i_tdata;
  assign src_q       = src_q_tdata;
  assign out_i_tdata = ch_i;
  assign out_q_tdata = ch_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    iq_path_ch #(
      .DW(DW), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .GUARD_LEN(GUARD_LEN)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .src_i     (src_i),
      .src_q     (src_q),
      .src_v     (src_tvalid),
      .cfg_valid (cfg_valid),
      .cfg_sel   (sel_in[c*SEL_W +: SEL_W]),
      .cfg_mode  (mode_in[c*2 +: 2]),
      .out_i     (ch_i[c]),
      .out_q     (ch_q[c]),
      .out_v     (out_tvalid[c]),
      .busy      (ch_busy[c]),
      .done      (done[c]),
      .bad       (bad[c])
    );
  end

  // Simultaneous guard completions all count, clamped at all-ones.
  always_comb begin
    n_done = '0;
    for (int c = 0; c < NUM_CH; c++) n_done = n_done + 5'(done[c]);
    cnt_sum = {1'b0, switch_cnt} + 17'(n_done);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_err    <= 1'b0;
      switch_cnt <= '0;
    end else begin
      sel_err    <= sel_err | (|bad);
      switch_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
endmodule

// File: tb/tb_iq_path_switch.sv
// Randomized scoreboard bench for iq_path_switch with a cycle-level behavioural model.
module tb_iq_path_switch;
  localparam int DW = 16, NUM_SRC = 4, NUM_CH = 2, SEL_W = 4, GUARD_LEN = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_SRC*DW-1:0]   src_i_tdata = '0, src_q_tdata = '0;
  logic [NUM_SRC-1:0]      src_tvalid = '0;
  logic [NUM_CH*SEL_W-1:0] sel_in = '0;
  logic [NUM_CH*2-1:0]     mode_in = '0;
  logic                    cfg_valid = 1'b0;
  logic [NUM_CH*DW-1:0]    out_i_tdata, out_q_tdata;
  logic [NUM_CH-1:0]       out_tvalid, ch_busy;
  logic                    sel_err;
  logic [15:0]             switch_cnt;

  iq_path_switch #(.DW(DW), .NUM_SRC(NUM_SRC), .NUM_CH(NUM_CH), .SEL_W(SEL_W),
                   .GUARD_LEN(GUARD_LEN)) dut (
    .clk(clk), .rst(rst), .src_i_tdata(src_i_tdata), .src_q_tdata(src_q_tdata),
    .src_tvalid(src_tvalid), .sel_in(sel_in), .mode_in(mode_in), .cfg_valid(cfg_valid),
    .out_i_tdata(out_i_tdata), .out_q_tdata(out_q_tdata), .out_tvalid(out_tvalid),
    .ch_busy(ch_busy), .sel_err(sel_err), .switch_cnt(switch_cnt));

  typedef struct {
    int                   due;
    logic [NUM_CH*DW-1:0] i, q;
    logic [NUM_CH-1:0]    v;
  } out_exp_t;
  typedef struct {
    int                due;
    logic [NUM_CH-1:0] busy;
    logic              err;
    logic [15:0]       cnt;
  } st_exp_t;

  out_exp_t oq[$];
  st_exp_t  stq[$];
  int checks = 0, failures = 0, ecnt = 0;
  bit mon_en = 1'b0;

  // stimulus
  logic [DW-1:0] si[NUM_SRC], sq[NUM_SRC];
  bit            sv[NUM_SRC];
  int            csel[NUM_CH], cmode[NUM_CH];
  bit            cfg;

  // reference model state
  int m_act_sel[NUM_CH], m_act_mode[NUM_CH], m_pend_sel[NUM_CH], m_pend_mode[NUM_CH];
  int m_guard[NUM_CH];
  int m_cnt;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] x);
    int v;
    v = -int'($signed(x));
    if (v > (2**(DW-1)) - 1) v = (2**(DW-1)) - 1;
    return DW'(v);
  endfunction

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0001;
      3: return 16'h0000;
      default: return DW'($urandom());
    endcase
  endfunction

  task automatic rand_src();
    for (int k = 0; k < NUM_SRC; k++) begin
      si[k] = pick();
      sq[k] = pick();
      sv[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_act_sel[c] = 0; m_act_mode[c] = 3; m_pend_sel[c] = 0; m_pend_mode[c] = 3;
      m_guard[c] = 0;
    end
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // Drive one input cycle (called at negedge) and queue what the DUT must show for it.
  task automatic drive_cycle();
    out_exp_t oe;
    st_exp_t  se;
    int       n_done;
    for (int k = 0; k < NUM_SRC; k++) begin
      src_i_tdata[k*DW +: DW] = si[k];
      src_q_tdata[k*DW +: DW] = sq[k];
      src_tvalid[k]           = sv[k];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      sel_in[c*SEL_W +: SEL_W] = SEL_W'(csel[c]);
      mode_in[c*2 +: 2]        = 2'(cmode[c]);
    end
    cfg_valid = cfg;
    oe.due = ecnt + 2;
    se.due = ecnt + 1;
    oe.i = '0; oe.q = '0; oe.v = '0; se.busy = '0;
    n_done = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      bit            g;
      int            r;
      logic [DW-1:0] di, dq, oi, oqv;
      g  = (m_guard[c] > 0);
      r  = g ? m_pend_sel[c] : m_act_sel[c];
      di = g ? '0 : si[r];
      dq = g ? '0 : sq[r];
      oe.v[c] = sv[r];
      if (cfg) begin
        if (csel[c] >= NUM_SRC) begin
          m_err = 1'b1; m_act_mode[c] = 3; m_guard[c] = 0;
        end else if (g || csel[c] != m_act_sel[c]) begin
          m_pend_sel[c] = csel[c]; m_pend_mode[c] = cmode[c]; m_guard[c] = GUARD_LEN;
        end else begin
          m_act_mode[c] = cmode[c];
        end
      end else if (g) begin
        m_guard[c]--;
        if (m_guard[c] == 0) begin
          m_act_sel[c] = m_pend_sel[c]; m_act_mode[c] = m_pend_mode[c]; n_done++;
        end
      end
      case (m_act_mode[c])
        0: begin oi = di; oqv = dq; end
        1: begin oi = di; oqv = neg_sat(dq); end
        2: begin oi = dq; oqv = di; end
        default: begin oi = '0; oqv = '0; end
      endcase
      oe.i[c*DW +: DW] = oi;
      oe.q[c*DW +: DW] = oqv;
      se.busy[c] = (m_guard[c] > 0);
    end
    m_cnt = (m_cnt + n_done > 65535) ? 65535 : m_cnt + n_done;
    se.cnt = 16'(m_cnt);
    se.err = m_err;
    oq.push_back(oe);
    stq.push_back(se);
  endtask

  task automatic cyc(input bit c);
    cfg = c;
    drive_cycle();
    @(negedge clk);
    cfg = 1'b0;
  endtask

  task automatic do_reset();
    out_exp_t oe;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_out_i", out_i_tdata, '0);
    chk("rst_out_q", out_q_tdata, '0);
    chk("rst_out_v", out_tvalid, '0);
    chk("rst_busy", ch_busy, '0);
    chk("rst_sel_err", sel_err, '0);
    chk("rst_switch_cnt", switch_cnt, '0);
    oq.delete();
    stq.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    oe.due = ecnt + 1; oe.i = '0; oe.q = '0; oe.v = '0;
    oq.push_back(oe);
    mon_en = 1'b1;
  endtask

  // Monitor: compares whatever the scoreboard says is due on this edge.
  initial begin
    out_exp_t oe;
    st_exp_t  se;
    forever begin
      @(posedge clk);
      ecnt++;
      #2;
      if (mon_en) begin
        if (stq.size() > 0 && stq[0].due == ecnt) begin
          se = stq.pop_front();
          chk("ch_busy", ch_busy, se.busy);
          chk("sel_err", sel_err, se.err);
          chk("switch_cnt", switch_cnt, se.cnt);
        end
        if (oq.size() > 0 && oq[0].due == ecnt) begin
          oe = oq.pop_front();
          chk("out_tvalid", out_tvalid, oe.v);
          for (int c = 0; c < NUM_CH; c++) begin
            if (oe.v[c]) begin
              chk($sformatf("ch%0d_i", c), out_i_tdata[c*DW +: DW], oe.i[c*DW +: DW]);
              chk($sformatf("ch%0d_q", c), out_q_tdata[c*DW +: DW], oe.q[c*DW +: DW]);
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, c0;
    for (int c = 0; c < NUM_CH; c++) begin csel[c] = 0; cmode[c] = 0; end
    cfg = 1'b0;
    rand_src();
    @(negedge clk);
    do_reset();

    // route ch0 to src1 pass; ch1 stays on src0 and just unmutes
    csel[0] = 1; cmode[0] = 0; csel[1] = 0; cmode[1] = 0;
    rand_src(); si[1] = 16'h1234; sq[1] = 16'h8000; sv[1] = 1'b1;
    cyc(1);
    repeat (GUARD_LEN + 4) begin
      rand_src(); si[1] = 16'h1234; sq[1] = 16'h8000; sv[1] = 1'b1; cyc(0);
    end
    chk("t2_i", out_i_tdata[DW-1:0], 16'h1234);
    chk("t2_q", out_q_tdata[DW-1:0], 16'h8000);

    // conj saturation on the same source
    cmode[0] = 1;
    rand_src(); si[1] = 16'h1234; sq[1] = 16'h8000; sv[1] = 1'b1;
    cyc(1);
    repeat (3) begin rand_src(); sq[1] = 16'h8000; sv[1] = 1'b1; cyc(0); end
    chk("t3_q_min", out_q_tdata[DW-1:0], 16'h7FFF);
    repeat (3) begin rand_src(); sq[1] = 16'h0001; sv[1] = 1'b1; cyc(0); end
    chk("t3_q_one", out_q_tdata[DW-1:0], 16'hFFFF);

    // guard length on src1 -> src2
    c0 = switch_cnt;
    csel[0] = 2; cmode[0] = 0;
    rand_src(); cyc(1);
    n = 0;
    repeat (30) begin if (ch_busy[0]) n++; rand_src(); cyc(0); end
    chk("t4_guard_len", n, GUARD_LEN);
    chk("t4_switch_inc", switch_cnt - 16'(c0), 1);

    // guard restart at guard cycle 10
    c0 = switch_cnt;
    csel[0] = 3;
    rand_src(); cyc(1);
    n = 0;
    repeat (9) begin if (ch_busy[0]) n++; rand_src(); cyc(0); end
    if (ch_busy[0]) n++;
    csel[0] = 0;
    rand_src(); cyc(1);
    repeat (30) begin if (ch_busy[0]) n++; rand_src(); cyc(0); end
    chk("t5_guard_total", n, 10 + GUARD_LEN);
    chk("t5_switch_inc", switch_cnt - 16'(c0), 1);

    // bad select on ch1
    csel[1] = NUM_SRC;
    rand_src(); cyc(1);
    repeat (5) begin rand_src(); cyc(0); end
    chk("t6_sel_err", sel_err, 1);
    chk("t6_ch1_i", out_i_tdata[DW +: DW], '0);
    chk("t6_ch1_q", out_q_tdata[DW +: DW], '0);

    // random traffic, then a mid-traffic reset, then more random traffic
    for (int pass = 0; pass < 2; pass++) begin
      repeat (1500) begin
        rand_src();
        for (int c = 0; c < NUM_CH; c++) begin
          csel[c]  = ($urandom_range(0, 19) == 0) ? NUM_SRC : $urandom_range(0, NUM_SRC - 1);
          cmode[c] = $urandom_range(0, 3);
        end
        cyc($urandom_range(0, 9) == 0);
      end
      if (pass == 0) do_reset();
    end
    repeat (3) begin rand_src(); cyc(0); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
